// File: rtl/par2ser_pkg.sv
// Shared state type and counter sizing for the par2ser transmitter.
package par2ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } p2s_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/p2s_hold_reg.sv
// One-entry valid/ready holding buffer; accepts when empty, empties on drain.
// Ready comes straight from the full flop, so there is no input-to-ready path.
module p2s_hold_reg
  import par2ser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             drain,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_full
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  // Drain only happens while full and accept only while empty, so they never collide.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (drain) begin
      full_d = 1'b0;
    end
    if (in_valid && !full_q) begin
      data_d = in_data;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign in_ready  = !full_q;
  assign hold_data = data_q;
  assign hold_full = full_q;

endmodule

// File: rtl/par2ser_tx.sv
// Parallel-to-serial transmitter: word in over valid/ready, one bit per en cycle out.
// First bit appears one edge after accept; the holding register lets words stream gap-free.
module par2ser_tx
  import par2ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             en,
  output logic             ser_valid,
  output logic             ser_data,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int            CW      = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  p2s_state_t       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             active;
  logic             at_end;
  logic             load;

  p2s_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .drain    (load),
    .hold_data(hold_data),
    .hold_full(hold_full)
  );

  assign active = (state_q == SHIFT);
  assign at_end = (cnt_q == CNT_MAX);
  // An idle shifter loads regardless of en; a running one only on its final enabled bit.
  assign load   = hold_full && (!active || (en && at_end));

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load) begin
      shift_d = hold_data;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (active && en) begin
      if (at_end) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (LSB_FIRST != 0) begin
          shift_d = {1'b0, shift_q[WIDTH-1:1]};
        end else begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ser_valid = active && en;
  assign ser_data  = (LSB_FIRST != 0) ? shift_q[0] : shift_q[WIDTH-1];
  assign ser_first = ser_valid && (cnt_q == '0);
  assign ser_last  = ser_valid && at_end;
  assign busy      = active || hold_full;

endmodule

// File: tb/tb_par2ser_tx.sv
// Bench for par2ser_tx: three instances (8-bit MSB-first, 8-bit LSB-first, 2-bit)
// checked each cycle against a word/bit-index model, plus literal expectations.
module tb_par2ser_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in2_valid = 1'b0;
  logic       en = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic [1:0] in2_data = 2'b00;
  logic [2:0] rdy, sv, sd, sf, sl, bz;

  int n_chk = 0;
  int n_fail = 0;
  bit tog = 1'b0;

  always #5 clk = ~clk;

  par2ser_tx #(.WIDTH(8), .LSB_FIRST(0)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
    .en(en), .ser_valid(sv[0]), .ser_data(sd[0]), .ser_first(sf[0]), .ser_last(sl[0]), .busy(bz[0])
  );
  par2ser_tx #(.WIDTH(8), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
    .en(en), .ser_valid(sv[1]), .ser_data(sd[1]), .ser_first(sf[1]), .ser_last(sl[1]), .busy(bz[1])
  );
  par2ser_tx #(.WIDTH(2), .LSB_FIRST(0)) u_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in2_valid), .in_ready(rdy[2]), .in_data(in2_data),
    .en(en), .ser_valid(sv[2]), .ser_data(sd[2]), .ser_first(sf[2]), .ser_last(sl[2]), .busy(bz[2])
  );

  // Model: a held word, the word in flight and the index of the bit now on the line.
  int         mw[3] = '{8, 8, 2};
  int         ml[3] = '{0, 1, 0};
  bit         m_full[3];
  bit         m_act[3];
  int         m_pos[3];
  logic [7:0] m_word[3];
  logic [7:0] m_cur[3];

  always @(posedge clk or negedge rst_n) begin : model
    bit         vld;
    logic [7:0] dat;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_full[i] = 1'b0;
        m_act[i]  = 1'b0;
        m_pos[i]  = 0;
        m_word[i] = 8'h00;
        m_cur[i]  = 8'h00;
      end else begin
        vld = (i == 2) ? in2_valid : in_valid;
        dat = (i == 2) ? {6'b0, in2_data} : in_data;
        if (m_act[i] && en) begin
          m_pos[i]++;
          if (m_pos[i] == mw[i]) m_act[i] = 1'b0;
        end
        if (!m_act[i] && m_full[i]) begin
          m_cur[i]  = m_word[i];
          m_pos[i]  = 0;
          m_act[i]  = 1'b1;
          m_full[i] = 1'b0;
        end else if (vld && !m_full[i]) begin
          m_word[i] = dat;
          m_full[i] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_bit(input int i);
    int idx;
    idx = (ml[i] != 0) ? m_pos[i] : (mw[i] - 1 - m_pos[i]);
    return m_cur[i][idx];
  endfunction

  int          nb[3], nf[3], nl[3], run[3], lrun[3];
  logic [31:0] cap[3];

  always @(negedge clk) begin : compare
    bit ev;
    for (int i = 0; i < 3; i++) begin
      ev = m_act[i] && en && rst_n;
      chk($sformatf("in_ready[%0d]", i), rdy[i], !m_full[i]);
      chk($sformatf("ser_valid[%0d]", i), sv[i], ev);
      chk($sformatf("busy[%0d]", i), bz[i], m_act[i] || m_full[i]);
      chk($sformatf("ser_first[%0d]", i), sf[i], ev && (m_pos[i] == 0));
      chk($sformatf("ser_last[%0d]", i), sl[i], ev && (m_pos[i] == mw[i] - 1));
      if (ev) chk($sformatf("ser_data[%0d]", i), sd[i], exp_bit(i));
      if (sv[i]) begin
        cap[i] = {cap[i][30:0], sd[i]};
        nb[i]++;
        nf[i] += int'(sf[i]);
        nl[i] += int'(sl[i]);
        run[i]++;
      end else begin
        if (run[i] != 0) lrun[i] = run[i];
        run[i] = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog) en = ~en;
  endtask

  task automatic send(input int sel, input logic [7:0] w);
    int k;
    k = 0;
    if (sel == 2) begin
      in2_valid = 1'b1;
      in2_data  = w[1:0];
    end else begin
      in_valid = 1'b1;
      in_data  = w;
    end
    while (!rdy[sel] && k < 50) begin
      tick();
      k++;
    end
    chk("send_wait_bound", 32'(k < 50), 32'd1);
    tick();
    in_valid  = 1'b0;
    in2_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base, base2, bf, bl, k;
    for (int i = 0; i < 3; i++) begin
      nb[i] = 0; nf[i] = 0; nl[i] = 0; run[i] = 0; lrun[i] = 0; cap[i] = 0;
    end

    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", 32'(rdy), 32'h7);
    chk("rst_busy", 32'(bz), 32'h0);
    chk("rst_ser_valid", 32'(sv), 32'h0);
    chk("rst_ser_data", 32'(sd), 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single word 0xC1, both bit orders
    base = nb[0];
    send(0, 8'hC1);
    chk("accept_no_bit_yet", 32'(sv[0]), 32'd0);
    chk("accept_busy", 32'(bz[0]), 32'd1);
    chk("ready_fell_after_accept", 32'(rdy[0]), 32'd0);
    tick();
    chk("first_bit_valid", 32'(sv[0]), 32'd1);
    chk("first_bit_first", 32'(sf[0]), 32'd1);
    chk("first_bit_msb_data", 32'(sd[0]), 32'd1);
    chk("first_bit_lsb_data", 32'(sd[1]), 32'd1);
    repeat (12) tick();
    chk("c1_bits", 32'(nb[0] - base), 32'd8);
    chk("c1_msb_seq", 32'(cap[0][7:0]), 32'hC1);
    chk("c1_lsb_seq", 32'(cap[1][7:0]), 32'h83);
    chk("c1_idle_busy", 32'(bz[0]), 32'd0);

    // Back-to-back 0xC1, 0x3E
    base = nb[0];
    bf = nf[0];
    send(0, 8'hC1);
    send(0, 8'h3E);
    repeat (20) tick();
    chk("b2b_bits", 32'(nb[0] - base), 32'd16);
    chk("b2b_run", 32'(lrun[0]), 32'd16);
    chk("b2b_msb_seq", 32'(cap[0][15:0]), 32'hC13E);
    chk("b2b_firsts", 32'(nf[0] - bf), 32'd2);

    // 0xFF with en toggling; second word accepted while en=0
    base = nb[0];
    tog = 1'b1;
    en = 1'b1;
    send(0, 8'hFF);
    tick();
    tog = 1'b0;
    en = 1'b0;
    send(0, 8'h5A);
    chk("en0_no_bit", 32'(sv[0]), 32'd0);
    chk("en0_accepted", 32'(rdy[0]), 32'd0);
    tog = 1'b1;
    repeat (44) tick();
    tog = 1'b0;
    en = 1'b1;
    repeat (4) tick();
    chk("entog_bits", 32'(nb[0] - base), 32'd16);
    chk("entog_seq", 32'(cap[0][15:0]), 32'hFF5A);

    // Reset after bit 3 with a word held
    base = nb[0];
    send(0, 8'hC1);
    send(0, 8'h3E);
    k = 0;
    while ((nb[0] - base) < 3 && k < 40) begin
      tick();
      k++;
    end
    chk("mid_reset_bits_before", 32'(nb[0] - base), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_ser_valid", 32'(sv), 32'h0);
    chk("mid_reset_ser_data", 32'(sd), 32'h0);
    chk("mid_reset_first_last", 32'({sf, sl}), 32'h0);
    chk("mid_reset_busy", 32'(bz), 32'h0);
    chk("mid_reset_in_ready", 32'(rdy), 32'h7);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("post_reset_no_bits", 32'(nb[0] - base), 32'd3);
    send(0, 8'h96);
    repeat (12) tick();
    chk("post_reset_new_word", 32'(nb[0] - base), 32'd11);
    chk("post_reset_seq", 32'(cap[0][7:0]), 32'h96);

    // WIDTH=2 stream 10, 01, 11
    base2 = nb[2];
    bf = nf[2];
    bl = nl[2];
    send(2, 8'h02);
    send(2, 8'h01);
    send(2, 8'h03);
    repeat (8) tick();
    chk("w2_bits", 32'(nb[2] - base2), 32'd6);
    chk("w2_seq", 32'(cap[2][5:0]), 32'b100111);
    chk("w2_run", 32'(lrun[2]), 32'd6);
    chk("w2_firsts", 32'(nf[2] - bf), 32'd3);
    chk("w2_lasts", 32'(nl[2] - bl), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
